// File: rtl/nios2_led_pio.sv
// Avalon-MM LED output PIO with a hardware blink engine (DATA, BLINK_MASK, PERIOD, SETCLR/STATUS).
// Define NIOS2_LED_PIO_SETCLR_EN to enable atomic set/clear writes at address 3.
module nios2_led_pio #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PRESCALE_W  = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_MASK   = 2'd1;
    localparam logic [1:0] A_PERIOD = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic [WIDTH-1:0]      data_q,   data_d;
    logic [WIDTH-1:0]      mask_q,   mask_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic [PRESCALE_W-1:0] cnt_q,    cnt_d;
    logic                  phase_q,  phase_d;
    logic [WIDTH-1:0]      out_q,    out_d;
    logic [31:0]           rdata_q,  rdata_d;

    logic wr_en;
    assign wr_en = chipselect & ~write_n;

    // Register file writes
    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (wr_en) begin
            case (address)
                A_DATA:   data_d   = writedata[WIDTH-1:0];
                A_MASK:   mask_d   = writedata[WIDTH-1:0];
                A_PERIOD: period_d = writedata[PRESCALE_W-1:0];
`ifdef NIOS2_LED_PIO_SETCLR_EN
                // Clear is applied after set so it wins on overlapping bits.
                A_STATUS: data_d   = (data_q | writedata[WIDTH-1:0]) & ~writedata[16+WIDTH-1:16];
`else
                A_STATUS: data_d   = data_q;
`endif
                default:  data_d   = data_q;
            endcase
        end
    end

    // Blink engine: cnt runs 0..PERIOD-1, phase flips on each wrap
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr_en && address == A_PERIOD) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_q - PRESCALE_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + PRESCALE_W'(1);
        end
    end

    // Output and read path use pre-edge register values
    always_comb begin
        out_d   = data_q ^ (mask_q & {WIDTH{phase_q}});
        rdata_d = '0;
        case (address)
            A_DATA:   rdata_d[WIDTH-1:0]      = data_q;
            A_MASK:   rdata_d[WIDTH-1:0]      = mask_q;
            A_PERIOD: rdata_d[PRESCALE_W-1:0] = period_q;
            A_STATUS: rdata_d[0]              = phase_q;
            default:  rdata_d                 = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            mask_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            out_q    <= RESET_VALUE;
            rdata_q  <= '0;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            out_q    <= out_d;
            rdata_q  <= rdata_d;
        end
    end

    assign out_port = out_q;
    assign readdata = rdata_q;

endmodule
